pipeline_mem_wb: RTL and testbench

Memory-access stage plus MEM/WB pipeline register of the 5-stage MIPS32 core. It consumes the EX/MEM register outputs, drives the data-memory request/acknowledge handshake, and stalls the upstream pipeline while an access is outstanding. Completed results go into the W-stage register that feeds register-file writeback and forwarding.

---
 rtl/pipeline_mem_wb_pkg.sv | 26 ++
 rtl/pipeline_mem_wb_dmem_handshake.sv | 129 ++++++++++++
 rtl/pipeline_mem_wb.sv | 137 +++++++++++++
 tb/tb_pipeline_mem_wb.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_mem_wb_pkg.sv
// Shared types for the MEM/WB stage: handshake state, word-align mask and the
// W-stage bundle consumed by writeback and the forwarding unit.
package pipe_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic        regWrite;
    logic        memtoReg;
    logic        fwd;
    logic        stop;
    logic [31:0] readData;
    logic [31:0] aluOut;
    logic [4:0]  writeReg;
  } wb_bus_t;

  function automatic logic [31:0] wordAddr(input logic [31:0] byteAddr);
    return byteAddr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pipeline_mem_wb_dmem_handshake.sv
// Data-memory request/ack handshake: IDLE/WAIT FSM, wait counter, request
// latch and Mealy stall generation.
module dmem_handshake
  import pipe_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        accReq,
  input  logic        writeReq,
  input  logic [31:0] addrIn,
  input  logic [31:0] wdataIn,
  input  logic        DMemAck,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [31:0] DMemWData,
  output logic        StallM,
  output logic        accDone,
  output logic        accTimeout
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

  mem_state_t  stateR;
  mem_state_t  stateNext;
  logic [7:0]  cntR;
  logic [7:0]  cntNext;
  logic        weR;
  logic [31:0] addrR;
  logic [31:0] wdataR;
  logic        reqS;
  logic        weS;
  logic        stallS;

  // State, wait counter and request-field latch
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stateR <= IDLE;
      cntR   <= 8'd0;
      weR    <= 1'b0;
      addrR  <= 32'd0;
      wdataR <= 32'd0;
    end else begin
      stateR <= stateNext;
      cntR   <= cntNext;
      if (stateR == IDLE && accReq) begin
        weR    <= writeReq;
        addrR  <= wordAddr(addrIn);
        wdataR <= wdataIn;
      end
    end
  end

  // Next-state and counter update; an ack in the last wait cycle beats the timeout
  always_comb begin
    stateNext = stateR;
    cntNext   = cntR;
    case (stateR)
      IDLE: begin
        if (accReq && !DMemAck) begin
          stateNext = WAIT;
          cntNext   = 8'd1;
        end else begin
          stateNext = IDLE;
          cntNext   = 8'd0;
        end
      end
      WAIT: begin
        if (DMemAck || cntR == MAX_CNT) begin
          stateNext = IDLE;
          cntNext   = 8'd0;
        end else begin
          stateNext = WAIT;
          cntNext   = cntR + 8'd1;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = 8'd0;
      end
    endcase
  end

  // Request fields, stall and completion strobes
  always_comb begin
    reqS       = 1'b0;
    weS        = 1'b0;
    DMemAddr   = wordAddr(addrIn);
    DMemWData  = wdataIn;
    stallS     = 1'b0;
    accDone    = 1'b0;
    accTimeout = 1'b0;
    case (stateR)
      IDLE: begin
        if (accReq) begin
          reqS    = 1'b1;
          weS     = writeReq;
          stallS  = !DMemAck;
          accDone = DMemAck;
        end else begin
          reqS = 1'b0;
        end
      end
      WAIT: begin
        reqS      = 1'b1;
        weS       = weR;
        DMemAddr  = addrR;
        DMemWData = wdataR;
        if (DMemAck) begin
          accDone = 1'b1;
        end else if (cntR == MAX_CNT) begin
          accTimeout = 1'b1;
        end else begin
          stallS = 1'b1;
        end
      end
      default: begin
        reqS = 1'b0;
      end
    endcase
  end

  assign DMemReq = reqS & RST_N;
  assign DMemWe  = weS & RST_N;
  assign StallM  = stallS & RST_N;

endmodule

// File: rtl/pipeline_mem_wb.sv
// MEM stage and MEM/WB register of the MIPS32 pipeline. Defining
// PIPE_MISALIGN_CHECK_EN suppresses misaligned accesses and adds sticky MisalignW.
module pipeline_mem_wb
  import pipe_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic        LoadM,
  input  logic        FwdMM,
  input  logic        StopM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  WriteRegM,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [31:0] DMemWData,
  input  logic [31:0] DMemRData,
  input  logic        DMemAck,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic        FwdMW,
  output logic        StopW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [4:0]  WriteRegW,
  output logic        HaltW,
  output logic        BusErrW
`ifdef PIPE_MISALIGN_CHECK_EN
  ,
  output logic        MisalignW
`endif
);

  logic    accS;
  logic    misalignS;
  logic    issueS;
  logic    accDone;
  logic    accTimeout;
  wb_bus_t mBus;
  wb_bus_t wR;
  wb_bus_t wNext;
  logic    haltR;
  logic    busErrR;

  assign accS = LoadM | MemWriteM;

`ifdef PIPE_MISALIGN_CHECK_EN
  logic misalignR;
  // A stalled access is already aligned, so this only ever fires from IDLE
  assign misalignS = accS & (ALUOutM[1:0] != 2'b00);
  assign MisalignW = misalignR;
`else
  assign misalignS = 1'b0;
`endif

  assign issueS = accS & ~misalignS;

  dmem_handshake #(
    .MAX_WAIT (MAX_WAIT)
  ) u_handshake (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .accReq     (issueS),
    .writeReq   (MemWriteM),
    .addrIn     (ALUOutM),
    .wdataIn    (WriteDataM),
    .DMemAck    (DMemAck),
    .DMemReq    (DMemReq),
    .DMemWe     (DMemWe),
    .DMemAddr   (DMemAddr),
    .DMemWData  (DMemWData),
    .StallM     (StallM),
    .accDone    (accDone),
    .accTimeout (accTimeout)
  );

  // Next W-register contents: capture, bubble, or suppressed misaligned access
  always_comb begin
    mBus.regWrite = RegWriteM;
    mBus.memtoReg = MemtoRegM;
    mBus.fwd      = FwdMM;
    mBus.stop     = StopM;
    mBus.readData = wR.readData;
    mBus.aluOut   = ALUOutM;
    mBus.writeReg = WriteRegM;
    wNext         = mBus;
    if (misalignS) begin
      wNext.regWrite = 1'b0;
    end else if (StallM || accTimeout) begin
      wNext          = wR;
      wNext.regWrite = 1'b0;
      wNext.memtoReg = 1'b0;
      wNext.stop     = 1'b0;
    end else if (accDone && LoadM) begin
      wNext.readData = DMemRData;
    end else begin
      wNext = mBus;
    end
  end

  // W register and sticky status flags
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wR      <= '0;
      haltR   <= 1'b0;
      busErrR <= 1'b0;
`ifdef PIPE_MISALIGN_CHECK_EN
      misalignR <= 1'b0;
`endif
    end else begin
      wR      <= wNext;
      haltR   <= haltR | wNext.stop;
      busErrR <= busErrR | accTimeout;
`ifdef PIPE_MISALIGN_CHECK_EN
      misalignR <= misalignR | misalignS;
`endif
    end
  end

  assign RegWriteW = wR.regWrite;
  assign MemtoRegW = wR.memtoReg;
  assign FwdMW     = wR.fwd;
  assign StopW     = wR.stop;
  assign ReadDataW = wR.readData;
  assign ALUOutW   = wR.aluOut;
  assign WriteRegW = wR.writeReg;
  assign HaltW     = haltR;
  assign BusErrW   = busErrR;

endmodule

// File: tb/tb_pipeline_mem_wb.sv
// Self-checking bench for pipeline_mem_wb: vector table, directed multi-cycle
// sequences and a randomized run against a transaction-level model.
module tb_pipeline_mem_wb;

  localparam int MW = 4;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        RegWriteM, MemtoRegM, MemWriteM, LoadM, FwdMM, StopM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM;
  logic        DMemReq, DMemWe;
  logic [31:0] DMemAddr, DMemWData, DMemRData;
  logic        DMemAck;
  logic        StallM;
  logic        RegWriteW, MemtoRegW, FwdMW, StopW;
  logic [31:0] ReadDataW, ALUOutW;
  logic [4:0]  WriteRegW;
  logic        HaltW, BusErrW;
`ifdef PIPE_MISALIGN_CHECK_EN
  logic        MisalignW;
`endif

  int errors = 0;
  int checks = 0;

  pipeline_mem_wb #(.MAX_WAIT(MW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .LoadM(LoadM), .FwdMM(FwdMM), .StopM(StopM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemWData(DMemWData),
    .DMemRData(DMemRData), .DMemAck(DMemAck), .StallM(StallM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .FwdMW(FwdMW), .StopW(StopW),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteRegW(WriteRegW),
    .HaltW(HaltW), .BusErrW(BusErrW)
`ifdef PIPE_MISALIGN_CHECK_EN
    , .MisalignW(MisalignW)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rw, mtr, mw, ld;
    logic [31:0] alu, wd;
    logic [4:0]  wr;
    logic        ack;
    logic [31:0] rd;
    logic        eReq, eWe;
    logic [31:0] eAddr;
    logic        eRw;
    logic [31:0] eRd;
  } vec_t;

  vec_t vecs [5];

  // Transaction-level model of the W outputs
  logic        mRw, mMtr, mFwd, mStop, mHalt, mBusErr;
  logic [31:0] mRd, mAlu;
  logic [4:0]  mWr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic setM(input logic rw, input logic mtr, input logic mw, input logic ld,
                      input logic fwd, input logic stp, input logic [31:0] alu,
                      input logic [31:0] wd, input logic [4:0] wr);
    RegWriteM = rw; MemtoRegM = mtr; MemWriteM = mw; LoadM = ld;
    FwdMM = fwd; StopM = stp; ALUOutM = alu; WriteDataM = wd; WriteRegM = wr;
  endtask

  task automatic toNeg();
    @(negedge CLK);
  endtask

  task automatic toPos();
    @(posedge CLK);
    #1;
  endtask

  task automatic chkModel(input string tag);
    chk({tag, ".RegWriteW"}, {31'd0, RegWriteW}, {31'd0, mRw});
    chk({tag, ".MemtoRegW"}, {31'd0, MemtoRegW}, {31'd0, mMtr});
    chk({tag, ".FwdMW"}, {31'd0, FwdMW}, {31'd0, mFwd});
    chk({tag, ".StopW"}, {31'd0, StopW}, {31'd0, mStop});
    chk({tag, ".ReadDataW"}, ReadDataW, mRd);
    chk({tag, ".ALUOutW"}, ALUOutW, mAlu);
    chk({tag, ".WriteRegW"}, {27'd0, WriteRegW}, {27'd0, mWr});
    chk({tag, ".HaltW"}, {31'd0, HaltW}, {31'd0, mHalt});
    chk({tag, ".BusErrW"}, {31'd0, BusErrW}, {31'd0, mBusErr});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 1'b0, 32'h0,
                1'b0, 1'b0, 32'h0, 1'b1, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 5'd8, 1'b1, 32'hDEAD_BEEF,
                1'b1, 1'b0, 32'h0000_0040, 1'b1, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0084, 32'hA1B2_C3D4, 5'd3, 1'b1, 32'h5555_5555,
                1'b1, 1'b1, 32'h0000_0084, 1'b0, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd31, 1'b1, 32'h0BAD_F00D,
                1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0, 5'd1, 1'b1, 32'h1234_5678,
                1'b1, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h1234_5678};

    // Reset with an access pending: handshake outputs must be forced low
    RST_N = 1'b0;
    setM(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h0, 5'd4);
    DMemAck = 1'b0; DMemRData = 32'h0;
    toNeg();
    chk("rst.DMemReq", {31'd0, DMemReq}, 32'd0);
    chk("rst.DMemWe", {31'd0, DMemWe}, 32'd0);
    chk("rst.StallM", {31'd0, StallM}, 32'd0);
    toPos();
    mRw = 1'b0; mMtr = 1'b0; mFwd = 1'b0; mStop = 1'b0; mHalt = 1'b0; mBusErr = 1'b0;
    mRd = 32'd0; mAlu = 32'd0; mWr = 5'd0;
    chkModel("rst");
    RST_N = 1'b1;

    // Single-cycle vectors: non-memory ops and zero-wait accesses
    for (int i = 0; i < 5; i++) begin
      setM(vecs[i].rw, vecs[i].mtr, vecs[i].mw, vecs[i].ld, 1'b0, 1'b0,
           vecs[i].alu, vecs[i].wd, vecs[i].wr);
      DMemAck = vecs[i].ack; DMemRData = vecs[i].rd;
      toNeg();
      chk($sformatf("vec%0d.DMemReq", i), {31'd0, DMemReq}, {31'd0, vecs[i].eReq});
      chk($sformatf("vec%0d.StallM", i), {31'd0, StallM}, 32'd0);
      if (vecs[i].eReq) begin
        chk($sformatf("vec%0d.DMemAddr", i), DMemAddr, vecs[i].eAddr);
        chk($sformatf("vec%0d.DMemWe", i), {31'd0, DMemWe}, {31'd0, vecs[i].eWe});
      end
      toPos();
      chk($sformatf("vec%0d.RegWriteW", i), {31'd0, RegWriteW}, {31'd0, vecs[i].eRw});
      chk($sformatf("vec%0d.ALUOutW", i), ALUOutW, vecs[i].alu);
      chk($sformatf("vec%0d.WriteRegW", i), {27'd0, WriteRegW}, {27'd0, vecs[i].wr});
      chk($sformatf("vec%0d.ReadDataW", i), ReadDataW, vecs[i].eRd);
    end

    // Store acked 3 cycles late: 3 stall cycles, stable write data, 3 bubbles
    setM(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 5'd2);
    DMemAck = 1'b0;
    toPos();
    setM(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'hA5A5_A5A5, 5'd7);
    for (int c = 0; c < 4; c++) begin
      DMemAck = (c == 3);
      toNeg();
      chk($sformatf("late%0d.StallM", c), {31'd0, StallM}, {31'd0, c < 3});
      chk($sformatf("late%0d.DMemReq", c), {31'd0, DMemReq}, 32'd1);
      chk($sformatf("late%0d.DMemWData", c), DMemWData, 32'hA5A5_A5A5);
      chk($sformatf("late%0d.DMemAddr", c), DMemAddr, 32'h80);
      toPos();
      if (c < 3) begin
        chk($sformatf("late%0d.bubble", c), {31'd0, RegWriteW}, 32'd0);
      end
    end
    chk("late.ALUOutW", ALUOutW, 32'h80);
    chk("late.WriteRegW", {27'd0, WriteRegW}, 32'd7);
    DMemAck = 1'b0;

    // Load with no ack: MW stall cycles, then abort with bus error
    setM(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 5'd9);
    for (int c = 0; c <= MW; c++) begin
      toNeg();
      chk($sformatf("tmo%0d.StallM", c), {31'd0, StallM}, {31'd0, c < MW});
      chk($sformatf("tmo%0d.DMemReq", c), {31'd0, DMemReq}, 32'd1);
      toPos();
      chk($sformatf("tmo%0d.BusErrW", c), {31'd0, BusErrW}, {31'd0, c == MW});
      chk($sformatf("tmo%0d.RegWriteW", c), {31'd0, RegWriteW}, 32'd0);
    end
    setM(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    toNeg();
    chk("tmo.after.DMemReq", {31'd0, DMemReq}, 32'd0);
    chk("tmo.after.StallM", {31'd0, StallM}, 32'd0);
    toPos();

    // Misaligned load
    setM(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h41, 32'h0, 5'd6);
    DMemAck = 1'b1; DMemRData = 32'hCAFE_F00D;
    toNeg();
`ifdef PIPE_MISALIGN_CHECK_EN
    chk("mis.DMemReq", {31'd0, DMemReq}, 32'd0);
    chk("mis.StallM", {31'd0, StallM}, 32'd0);
    toPos();
    chk("mis.MisalignW", {31'd0, MisalignW}, 32'd1);
    chk("mis.RegWriteW", {31'd0, RegWriteW}, 32'd0);
    chk("mis.ALUOutW", ALUOutW, 32'h41);
`else
    chk("mis.DMemReq", {31'd0, DMemReq}, 32'd1);
    chk("mis.DMemAddr", DMemAddr, 32'h40);
    toPos();
    chk("mis.ReadDataW", ReadDataW, 32'hCAFE_F00D);
    chk("mis.RegWriteW", {31'd0, RegWriteW}, 32'd1);
`endif
    DMemAck = 1'b0;

    // Fresh reset, then randomized instruction stream against the model
    RST_N = 1'b0;
    setM(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    toPos();
    RST_N = 1'b1;
    mRw = 1'b0; mMtr = 1'b0; mFwd = 1'b0; mStop = 1'b0; mHalt = 1'b0; mBusErr = 1'b0;
    mRd = 32'd0; mAlu = 32'd0; mWr = 5'd0;

    for (int n = 0; n < 300; n++) begin
      int          typ, d, k;
      logic        ld, st, acc, rw, stp, fwd, mtr;
      logic [31:0] alu, wd, ackData, tmp;
      logic [4:0]  wr;
      typ = $urandom_range(0, 2);
      ld = (typ == 1); st = (typ == 2); acc = ld | st;
      rw  = ld ? 1'b1 : (st ? 1'b0 : 1'($urandom_range(0, 1)));
      mtr = ld;
      fwd = 1'($urandom_range(0, 1));
      stp = ($urandom_range(0, 15) == 0);
      tmp = $urandom();
      alu = acc ? (tmp & 32'hFFFF_FFFC) : tmp;
      wd  = $urandom();
      wr  = 5'($urandom_range(0, 31));
      d   = $urandom_range(0, MW + 1);
      k   = acc ? ((d <= MW) ? d : MW) : 0;
      ackData = 32'd0;
      setM(rw, mtr, st, ld, fwd, stp, alu, wd, wr);
      for (int c = 0; c <= k; c++) begin
        DMemAck   = acc ? (c == d) : 1'($urandom_range(0, 1));
        DMemRData = $urandom();
        if (acc && c == d) ackData = DMemRData;
        toNeg();
        chk($sformatf("rnd%0d.DMemReq", n), {31'd0, DMemReq}, {31'd0, acc});
        chk($sformatf("rnd%0d.StallM", n), {31'd0, StallM}, {31'd0, acc && (c < k)});
        if (acc) begin
          chk($sformatf("rnd%0d.DMemAddr", n), DMemAddr, alu);
          chk($sformatf("rnd%0d.DMemWe", n), {31'd0, DMemWe}, {31'd0, st});
          chk($sformatf("rnd%0d.DMemWData", n), DMemWData, wd);
        end
        toPos();
        if (c < k) begin
          chk($sformatf("rnd%0d.bubbleRW", n), {31'd0, RegWriteW}, 32'd0);
          chk($sformatf("rnd%0d.bubbleStop", n), {31'd0, StopW}, 32'd0);
        end
      end
      if (acc && d > MW) begin
        mRw = 1'b0; mMtr = 1'b0; mStop = 1'b0; mBusErr = 1'b1;
      end else begin
        mRw = rw; mMtr = mtr; mFwd = fwd; mStop = stp; mAlu = alu; mWr = wr;
        if (ld) mRd = ackData;
      end
      mHalt = mHalt | mStop;
      chkModel($sformatf("rnd%0d", n));
    end
    DMemAck = 1'b0;

    // Reset during WAIT abandons the access; halt is sticky afterwards
    setM(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 5'd10);
    toNeg();
    chk("rstw.StallM0", {31'd0, StallM}, 32'd1);
    toPos();
    toNeg();
    chk("rstw.DMemReq1", {31'd0, DMemReq}, 32'd1);
    RST_N = 1'b0;
    #1;
    chk("rstw.DMemReqForced", {31'd0, DMemReq}, 32'd0);
    chk("rstw.StallMForced", {31'd0, StallM}, 32'd0);
    toPos();
    mRw = 1'b0; mMtr = 1'b0; mFwd = 1'b0; mStop = 1'b0; mHalt = 1'b0; mBusErr = 1'b0;
    mRd = 32'd0; mAlu = 32'd0; mWr = 5'd0;
    chkModel("rstw");
    RST_N = 1'b1;
    setM(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    toNeg();
    chk("rstw.idleReq", {31'd0, DMemReq}, 32'd0);
    chk("rstw.idleStall", {31'd0, StallM}, 32'd0);
    toPos();
    setM(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 5'd0);
    toPos();
    chk("halt.StopW", {31'd0, StopW}, 32'd1);
    chk("halt.HaltW", {31'd0, HaltW}, 32'd1);
    setM(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    toPos();
    chk("halt.StopWclr", {31'd0, StopW}, 32'd0);
    chk("halt.HaltWsticky", {31'd0, HaltW}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
